// File: rtl/arr_set_sched.sv
// arr_set_sched: round-robin scheduler plus storage for a DEPTH-entry array of
// WIDTH-bit words. Two requesters issue indexed set commands. A set command
// either writes a literal value or copies another element of the array. At
// most one command commits per cycle, and the whole array is driven on O.
//
// Optional feature: define ARR_SET_CLEAR_EN to add a synchronous 'clr' input.
// While 'clr' is high, both readys are held low and the array is zeroed at
// the next edge.
module arr_set_sched #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 9,
  parameter int IDXW  = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IDXW-1:0]  req0_idx,
  input  logic             req0_copy,
  input  logic [IDXW-1:0]  req0_src,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IDXW-1:0]  req1_idx,
  input  logic             req1_copy,
  input  logic [IDXW-1:0]  req1_src,
  input  logic [WIDTH-1:0] req1_data,
`ifdef ARR_SET_CLEAR_EN
  input  logic             clr,
`endif
  output logic [WIDTH-1:0] O [DEPTH-1:0],
  output logic             err,
  output logic             last_gnt
);

  // Index comparisons are done one bit wider than IDXW so that DEPTH itself
  // is representable even when DEPTH == 2**IDXW.
  localparam logic [IDXW:0] DEPTH_W = (IDXW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             rr_q, rr_d;
  logic             err_q, err_d;
  logic             last_gnt_q, last_gnt_d;

  logic             gnt_any;
  logic             gnt_sel;
  logic [IDXW-1:0]  sel_idx;
  logic [IDXW-1:0]  sel_src;
  logic             sel_copy;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] src_val;
  logic             idx_bad;
  logic             src_bad;

  // Arbitration: a lone valid requester wins, and under contention rr picks the winner.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_sel = (req0_valid & req1_valid) ? rr_q : req1_valid;
`ifdef ARR_SET_CLEAR_EN
    if (clr) begin
      gnt_any = 1'b0;
    end
`endif
    req0_ready = gnt_any & ~gnt_sel;
    req1_ready = gnt_any & gnt_sel;
  end

  // Select the winning command and decode its indices against the array size.
  always_comb begin
    sel_idx  = gnt_sel ? req1_idx  : req0_idx;
    sel_src  = gnt_sel ? req1_src  : req0_src;
    sel_copy = gnt_sel ? req1_copy : req0_copy;
    sel_data = gnt_sel ? req1_data : req0_data;
    idx_bad  = {1'b0, sel_idx} >= DEPTH_W;
    src_bad  = {1'b0, sel_src} >= DEPTH_W;
    src_val  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_src == IDXW'(i)) begin
        src_val = mem_q[i];
      end
    end
  end

  // Next state: commit the accepted command, or flag it as an error when it names a missing element.
  always_comb begin
    mem_d      = mem_q;
    rr_d       = rr_q;
    last_gnt_d = last_gnt_q;
    err_d      = 1'b0;
    if (gnt_any) begin
      rr_d       = ~gnt_sel;
      last_gnt_d = gnt_sel;
      err_d      = idx_bad | (sel_copy & src_bad);
      if (!(idx_bad | (sel_copy & src_bad))) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (sel_idx == IDXW'(i)) begin
            mem_d[i] = sel_copy ? src_val : sel_data;
          end
        end
      end
    end
`ifdef ARR_SET_CLEAR_EN
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end
`endif
  end

  // State registers. Reset clears the array immediately and drops any in-flight accept.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rr_q       <= 1'b0;
      err_q      <= 1'b0;
      last_gnt_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rr_q       <= rr_d;
      err_q      <= err_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      O[i] = mem_q[i];
    end
    err      = err_q;
    last_gnt = last_gnt_q;
  end

endmodule

// File: tb/tb_arr_set_sched.sv
// Testbench for arr_set_sched. A table of command vectors holds the expected
// ready values and the expected error flag for each vector. A reference array
// model turns each accepted command into an expected post-edge state. That
// state is pushed onto a queue and popped once the edge has happened.
module tb_arr_set_sched;

  localparam int WIDTH = 32;
  localparam int DEPTH = 9;
  localparam int IDXW  = 4;

  logic             CLK = 1'b0;
  logic             ASYNCRESET;
  logic             req0_valid, req0_ready, req0_copy;
  logic [IDXW-1:0]  req0_idx, req0_src;
  logic [WIDTH-1:0] req0_data;
  logic             req1_valid, req1_ready, req1_copy;
  logic [IDXW-1:0]  req1_idx, req1_src;
  logic [WIDTH-1:0] req1_data;
  logic [WIDTH-1:0] O [DEPTH-1:0];
  logic             err;
  logic             last_gnt;
`ifdef ARR_SET_CLEAR_EN
  logic             clr;
`endif

  always #5 CLK = ~CLK;

  arr_set_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_idx(req0_idx),
    .req0_copy(req0_copy), .req0_src(req0_src), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_idx(req1_idx),
    .req1_copy(req1_copy), .req1_src(req1_src), .req1_data(req1_data),
`ifdef ARR_SET_CLEAR_EN
    .clr(clr),
`endif
    .O(O), .err(err), .last_gnt(last_gnt)
  );

  typedef struct packed {
    logic             v0;
    logic [IDXW-1:0]  i0;
    logic             c0;
    logic [IDXW-1:0]  s0;
    logic [WIDTH-1:0] d0;
    logic             v1;
    logic [IDXW-1:0]  i1;
    logic             c1;
    logic [IDXW-1:0]  s1;
    logic [WIDTH-1:0] d1;
    logic             rdy0;
    logic             rdy1;
    logic             err;
  } vec_t;

  typedef struct packed {
    logic [DEPTH*WIDTH-1:0] mem;
    logic                   err;
    logic                   lg;
  } exp_t;

  vec_t             vecs [16];
  exp_t             sb_q [$];
  logic [WIDTH-1:0] mem_m [DEPTH];
  logic             lg_m;
  int               checks;
  int               passes;

  function automatic vec_t mk(input logic v0, input int i0, input logic c0, input int s0,
                              input logic [WIDTH-1:0] d0,
                              input logic v1, input int i1, input logic c1, input int s1,
                              input logic [WIDTH-1:0] d1,
                              input logic rdy0, input logic rdy1, input logic e);
    vec_t v;
    v.v0 = v0; v.i0 = IDXW'(i0); v.c0 = c0; v.s0 = IDXW'(s0); v.d0 = d0;
    v.v1 = v1; v.i1 = IDXW'(i1); v.c1 = c1; v.s1 = IDXW'(s1); v.d1 = d1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.err = e;
    return v;
  endfunction

  task automatic check1(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    lg_m = 1'b0;
    sb_q.delete();
  endtask

  task automatic push_expected(input logic e);
    exp_t x;
    for (int i = 0; i < DEPTH; i++) x.mem[i*WIDTH +: WIDTH] = mem_m[i];
    x.err = e;
    x.lg  = lg_m;
    sb_q.push_back(x);
  endtask

  // Compare the post-edge DUT state against the oldest scoreboard entry.
  task automatic checkOutput(input string tag);
    exp_t x;
    int   bad;
    checks++;
    if (sb_q.size() == 0) begin
      $display("[TB] FAIL %s scoreboard empty actual=0 required=1", tag);
      return;
    end
    passes++;
    x = sb_q.pop_front();
    bad = -1;
    for (int i = 0; i < DEPTH; i++)
      if (bad < 0 && O[i] !== x.mem[i*WIDTH +: WIDTH]) bad = i;
    checks++;
    if (bad < 0) passes++;
    else $display("[TB] FAIL %s O[%0d] actual=%0h required=%0h", tag, bad, O[bad], x.mem[bad*WIDTH +: WIDTH]);
    check1({tag, " err"}, WIDTH'(err), WIDTH'(x.err));
    check1({tag, " last_gnt"}, WIDTH'(last_gnt), WIDTH'(x.lg));
  endtask

  // Drive one vector shortly after a rising edge, check ready, update the model, then check after the edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    logic             acc, cp, e;
    logic [IDXW-1:0]  ix, sx;
    logic [WIDTH-1:0] dx;
    req0_valid = v.v0; req0_idx = v.i0; req0_copy = v.c0; req0_src = v.s0; req0_data = v.d0;
    req1_valid = v.v1; req1_idx = v.i1; req1_copy = v.c1; req1_src = v.s1; req1_data = v.d1;
    #2;
    check1({tag, " req0_ready"}, WIDTH'(req0_ready), WIDTH'(v.rdy0));
    check1({tag, " req1_ready"}, WIDTH'(req1_ready), WIDTH'(v.rdy1));
    acc = v.rdy0 | v.rdy1;
    ix = v.rdy1 ? v.i1 : v.i0;
    sx = v.rdy1 ? v.s1 : v.s0;
    cp = v.rdy1 ? v.c1 : v.c0;
    dx = v.rdy1 ? v.d1 : v.d0;
    e = 1'b0;
    if (acc) begin
      lg_m = v.rdy1;
      if (int'(ix) >= DEPTH || (cp && int'(sx) >= DEPTH)) e = 1'b1;
      else mem_m[ix] = cp ? mem_m[sx] : dx;
    end
    check1({tag, " table err"}, WIDTH'(e), WIDTH'(v.err));
    push_expected(e);
    @(posedge CLK); #1;
    checkOutput(tag);
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_idx = '0; req0_copy = 0; req0_src = '0; req0_data = '0;
    req1_valid = 0; req1_idx = '0; req1_copy = 0; req1_src = '0; req1_data = '0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    idle_inputs();
`ifdef ARR_SET_CLEAR_EN
    clr = 1'b0;
`endif
    ASYNCRESET = 1'b1;
    model_reset();

    vecs[0]  = mk(1, 7, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        1, 0, 0);
    vecs[1]  = mk(1, 3, 0, 0, 32'h11,       0, 0, 0, 0, 32'h0,        1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0,        1, 7, 1, 3, 32'h99,       0, 1, 0);
    vecs[3]  = mk(1, 9, 0, 0, 32'h1234,     0, 0, 0, 0, 32'h0,        1, 0, 1);
    vecs[4]  = mk(0, 1, 0, 0, 32'h5555,     0, 2, 0, 0, 32'h6666,     0, 0, 0);
    vecs[5]  = mk(1, 2, 0, 0, 32'h5,        0, 0, 0, 0, 32'h0,        1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,        1, 4, 1, 2, 32'h77,       0, 1, 0);
    vecs[7]  = mk(1, 0, 0, 0, 32'hA0,       1, 1, 0, 0, 32'hB1,       1, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 32'hA2,       1, 1, 0, 0, 32'hB3,       0, 1, 0);
    vecs[9]  = mk(1, 0, 0, 0, 32'hA4,       1, 1, 0, 0, 32'hB5,       1, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 32'hA6,       1, 1, 0, 0, 32'hB7,       0, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,        1, 5, 1, 12, 32'h88,      0, 1, 1);
    vecs[12] = mk(1, 6, 1, 6, 32'h42,       0, 0, 0, 0, 32'h0,        1, 0, 0);
    vecs[13] = mk(1, 15, 1, 0, 32'h43,      0, 0, 0, 0, 32'h0,        1, 0, 1);
    vecs[14] = mk(1, 0, 0, 0, 32'hFFFFFFFF, 1, 8, 0, 0, 32'hCAFEF00D, 0, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 32'h0,        1, 1, 1, 8, 32'h0,        0, 1, 0);

    // Reset state
    repeat (2) @(posedge CLK);
    #1 ASYNCRESET = 1'b0;
    #2;
    check1("reset O[0]", O[0], '0);
    check1("reset O[8]", O[8], '0);
    check1("reset err", WIDTH'(err), '0);
    check1("reset last_gnt", WIDTH'(last_gnt), '0);
    @(posedge CLK); #1;

    // Main table
    for (int k = 0; k < 16; k++) applyStimulus(vecs[k], $sformatf("vec%0d", k));

    // Mid-stream reset: the array clears at once and the in-flight write is dropped
    req0_valid = 1; req0_idx = 4'd3; req0_copy = 0; req0_data = 32'h77;
    #2 ASYNCRESET = 1'b1;
    #1;
    check1("midreset O[7]", O[7], '0);
    check1("midreset O[8]", O[8], '0);
    @(posedge CLK); #1;
    idle_inputs();
    ASYNCRESET = 1'b0;
    model_reset();
    #2;
    check1("midreset drop O[3]", O[3], '0);
    check1("midreset last_gnt", WIDTH'(last_gnt), '0);
    @(posedge CLK); #1;

    // Continuous dual contention from reset: the grants must alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      applyStimulus(mk(1, 1, 0, 0, WIDTH'(k + 32'h10), 1, 2, 0, 0, WIDTH'(k + 32'h20),
                       (k % 2) == 0, (k % 2) == 1, 0), $sformatf("contend%0d", k));
    end

`ifdef ARR_SET_CLEAR_EN
    // Clear has priority over a valid request
    req0_valid = 1; req0_idx = 4'd5; req0_copy = 0; req0_data = 32'hABCD;
    req1_valid = 0;
    clr = 1'b1;
    #2;
    check1("clr req0_ready", WIDTH'(req0_ready), '0);
    check1("clr req1_ready", WIDTH'(req1_ready), '0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    push_expected(1'b0);
    @(posedge CLK); #1;
    clr = 1'b0;
    checkOutput("clr");
`endif

    idle_inputs();
    check1("scoreboard drained", WIDTH'(sb_q.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
